fwd_buf_arbiter: RTL and testbench
==================================

Name: fwd_buf_arbiter

Overview:
- Shares one axistream_forwarder between N_BUFS packet-memory buffers (ping-pong/multi-buffer packetmem instances).
- Picks a ready buffer round-robin and holds the grant for one whole packet.
- Routes the forwarder's read port and handshake to the granted buffer; releases it on forwarder_done.
- Sits between the forwarder's packetmem-facing interface and the buffer array.

Parameters:
- N_BUFS, 4, number of buffers arbitrated (2..16).
- DATA_WIDTH, 64, flit width.
- ADDR_WIDTH, 9, buffer word-address width; length width PLEN = ADDR_WIDTH+1.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset: synchronous, active-high.
- forwarder_rd_addr  in  ADDR_WIDTH  read address from the forwarder.
- forwarder_rd_en  in  1  read enable from the forwarder.
- forwarder_rd_data  out  DATA_WIDTH  muxed read data to the forwarder.
- forwarder_done  in  1  1-cycle end-of-packet pulse from the forwarder.
- ready_for_forwarder  out  1  granted buffer's ready, gated by the BUSY state.
- len_to_forwarder  out  PLEN  granted buffer's length.
- buf_ready  in  N_BUFS  per-buffer packet-ready flags.
- buf_len  in  N_BUFS*PLEN  flattened lengths; buffer i is at [i*PLEN +: PLEN].
- buf_rd_addr  out  ADDR_WIDTH  broadcast read address.
- buf_rd_en  out  N_BUFS  one-hot read enable.
- buf_rd_data  in  N_BUFS*DATA_WIDTH  flattened read data.
- buf_done  out  N_BUFS  one-hot 1-cycle release pulse.

Behaviour:
- Reset values:
  - state=IDLE, grant=0, sel=0.
  - rr_ptr=N_BUFS-1, so buffer 0 wins first.
  - ready_for_forwarder=0, len_to_forwarder=0, buf_rd_en=0, buf_done=0.
- Reset mid-packet: grant is dropped immediately and no buf_done is pulsed. The buffer stays ready and is re-arbitrated after reset.
- IDLE:
  - If any buf_ready bit is set, register grant = first set index scanning (rr_ptr+1) mod N upward with wrap.
  - sel<=grant; go BUSY.
  - Latency: buf_ready rising at cycle t gives ready_for_forwarder=1 at t+1.
  - If no buffer is ready, stay in IDLE.
- BUSY, with g = the granted index:
  - ready_for_forwarder = buf_ready[g].
  - len_to_forwarder = buf_len[g].
  - buf_rd_en = forwarder_rd_en one-hot at bit g.
  - buf_rd_addr = forwarder_rd_addr (broadcast, valid only where rd_en is high).
- Read-data mux: forwarder_rd_data = buf_rd_data[sel], combinational.
  - sel changes only on a new grant; it is held through IDLE.
  - This keeps a pending last flit stable (packetmem read latency is 1 cycle).
- Release:
  - forwarder_done while BUSY sets buf_done[g]=1 in the same cycle (combinational).
  - Next edge: rr_ptr<=g, grant cleared, state<=IDLE.
  - Minimum gap: one IDLE cycle between packets.
- forwarder_done while IDLE is ignored: no buf_done pulse, no state change.
- If buf_ready[g] falls while BUSY, ready_for_forwarder falls with it (the forwarder stalls). The grant is held until done.
- Fairness: if all buffers are continuously ready, grants cycle 0,1,...,N-1,0. No buffer waits more than N-1 packets.
- In IDLE, ready_for_forwarder, buf_rd_en and buf_done are all 0, whatever the inputs.

Optional Feature:
- FWD_BUF_ARBITER_STATS_EN defined:
  - Adds output pkt_count [N_BUFS*32-1:0]. Buffer i's counter increments on each buf_done[i] pulse and wraps at 2^32.
  - Adds output busy_cycles [31:0], counting cycles in BUSY.
  - All counters clear on rst.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared header fwd_defs.vh:
  - PLEN width macro (ADDR_WIDTH+1).
  - State encodings FWD_ARB_IDLE=1'b0, FWD_ARB_BUSY=1'b1.
- Sub-module rr_picker:
  - Purely combinational.
  - Inputs: request vector and rr_ptr. Outputs: one-hot winner and its index, plus a valid flag.
  - Parameterised by N_BUFS. Reusable by future ingress arbitration.

Test Plan:
- Single buffer: N=4, buf_ready=4'b0100, buf_len[2]=16.
  - Grant 2 one cycle later; len_to_forwarder=16.
  - buf_rd_en=4'b0100 whenever forwarder_rd_en=1.
  - On done, buf_done=4'b0100 for exactly 1 cycle; IDLE next cycle.
- Round-robin: buf_ready=4'b1111 held, 8 packets.
  - Grant order 0,1,2,3,0,1,2,3.
  - Exactly one IDLE cycle between packets.
- Wrap/skip: after grant 3, buf_ready=4'b0100 → next grant is 2.
- Data mux: buf_rd_data[1]=64'hA5A5..., buf_rd_data[0]=64'h1111....
  - Grant 1 gives forwarder_rd_data=A5A5....
  - It still reads A5A5... in the IDLE cycle after done.
- Reset mid-packet: rst asserted while BUSY on buffer 2.
  - No buf_done pulse; all outputs 0 on the next cycle.
  - With buffer 2 still ready after rst release, buffer 2 is granted first only if no lower index is ready (rr_ptr=3).
- Spurious/stall: forwarder_done pulsed in IDLE → no buf_done.
  - buf_ready[g] dropped for 3 cycles in BUSY → ready_for_forwarder low for those 3 cycles; grant unchanged.

Source files
------------

// File: rtl/fwd_buf_arbiter_pkg.sv
// ============================================================================
// Module  : fwd_buf_arbiter_pkg
// Brief   : Shared state encoding and width helpers for the forwarder arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fwd_buf_arbiter_pkg;

    typedef enum logic {
        FWD_ARB_IDLE = 1'b0,
        FWD_ARB_BUSY = 1'b1
    } fwd_arb_state_e;

    localparam int STAT_W = 32;

    // Packet length needs one more bit than the word address to hold a full buffer.
    function automatic int fwd_plen(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_buf_arbiter_rr_picker.sv
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin picker; scans upward from rr_ptr+1 with wrap.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter  int N_BUFS = 4,
    localparam int IDX_W  = $clog2(N_BUFS)
) (
    input  logic [N_BUFS-1:0] req,
    input  logic [IDX_W-1:0]  rr_ptr,
    output logic [N_BUFS-1:0] win_onehot,
    output logic [IDX_W-1:0]  win_idx,
    output logic              win_valid
);

    int cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        cand       = 0;
        for (int i = 1; i <= N_BUFS; i++) begin
            cand = (int'(rr_ptr) + i) % N_BUFS;
            if (!win_valid && req[cand]) begin
                win_valid        = 1'b1;
                win_idx          = IDX_W'(cand);
                win_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fwd_buf_arbiter.sv
// ============================================================================
// Module  : fwd_buf_arbiter
// Brief   : Shares one axistream_forwarder between N_BUFS packet buffers,
//           granting round-robin for one whole packet. Optional statistics
//           counters are enabled with FWD_BUF_ARBITER_STATS_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fwd_buf_arbiter
    import fwd_buf_arbiter_pkg::*;
#(
    parameter  int N_BUFS     = 4,
    parameter  int DATA_WIDTH = 64,
    parameter  int ADDR_WIDTH = 9,
    localparam int PLEN       = fwd_plen(ADDR_WIDTH),
    localparam int IDX_W      = $clog2(N_BUFS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        forwarder_rd_addr,
    input  logic                         forwarder_rd_en,
    output logic [DATA_WIDTH-1:0]        forwarder_rd_data,
    input  logic                         forwarder_done,
    output logic                         ready_for_forwarder,
    output logic [PLEN-1:0]              len_to_forwarder,
    input  logic [N_BUFS-1:0]            buf_ready,
    input  logic [N_BUFS*PLEN-1:0]       buf_len,
    output logic [ADDR_WIDTH-1:0]        buf_rd_addr,
    output logic [N_BUFS-1:0]            buf_rd_en,
    input  logic [N_BUFS*DATA_WIDTH-1:0] buf_rd_data,
    output logic [N_BUFS-1:0]            buf_done
`ifdef FWD_BUF_ARBITER_STATS_EN
    ,
    output logic [N_BUFS*STAT_W-1:0]     pkt_count,
    output logic [STAT_W-1:0]            busy_cycles
`endif
);

    fwd_arb_state_e    state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [N_BUFS-1:0] grant_oh_q, grant_oh_d;
    logic [IDX_W-1:0]  sel_q, sel_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [N_BUFS-1:0] pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic              busy;

    rr_picker #(.N_BUFS(N_BUFS)) u_picker (
        .req        (buf_ready),
        .rr_ptr     (rr_ptr_q),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .win_valid  (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            FWD_ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick_idx;
                    grant_oh_d = pick_onehot;
                    sel_d      = pick_idx;
                    state_d    = FWD_ARB_BUSY;
                end
            end
            FWD_ARB_BUSY: begin
                if (forwarder_done) begin
                    rr_ptr_d   = grant_q;
                    grant_d    = '0;
                    grant_oh_d = '0;
                    state_d    = FWD_ARB_IDLE;
                end
            end
            default: state_d = FWD_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FWD_ARB_IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            sel_q      <= '0;
            rr_ptr_q   <= IDX_W'(N_BUFS - 1);
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Masking with rst drops the grant in the reset cycle itself, so no stray release escapes.
    assign busy = (state_q == FWD_ARB_BUSY) && !rst;

    always_comb begin
        ready_for_forwarder = 1'b0;
        len_to_forwarder    = '0;
        buf_rd_en           = '0;
        buf_done            = '0;
        if (busy) begin
            ready_for_forwarder = buf_ready[grant_q];
            len_to_forwarder    = buf_len[int'(grant_q)*PLEN +: PLEN];
            buf_rd_en           = {N_BUFS{forwarder_rd_en}} & grant_oh_q;
            buf_done            = {N_BUFS{forwarder_done}} & grant_oh_q;
        end
    end

    assign buf_rd_addr = forwarder_rd_addr;

    // sel survives the release so the final flit's 1-cycle-late read data stays routed.
    assign forwarder_rd_data = buf_rd_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];

`ifdef FWD_BUF_ARBITER_STATS_EN
    logic [N_BUFS*STAT_W-1:0] pkt_count_q, pkt_count_d;
    logic [STAT_W-1:0]        busy_cycles_q, busy_cycles_d;

    always_comb begin
        pkt_count_d   = pkt_count_q;
        busy_cycles_d = busy_cycles_q;
        for (int i = 0; i < N_BUFS; i++) begin
            if (buf_done[i]) begin
                pkt_count_d[i*STAT_W +: STAT_W] = pkt_count_q[i*STAT_W +: STAT_W] + 1'b1;
            end
        end
        if (state_q == FWD_ARB_BUSY) begin
            busy_cycles_d = busy_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q   <= '0;
            busy_cycles_q <= '0;
        end else begin
            pkt_count_q   <= pkt_count_d;
            busy_cycles_q <= busy_cycles_d;
        end
    end

    assign pkt_count   = pkt_count_q;
    assign busy_cycles = busy_cycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_buf_arbiter.sv
// ============================================================================
// Module  : tb_fwd_buf_arbiter
// Brief   : Self-checking bench for fwd_buf_arbiter (default build, N_BUFS=4).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fwd_buf_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 9;
    localparam int PL = AW + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     forwarder_rd_addr;
    logic              forwarder_rd_en;
    logic [DW-1:0]     forwarder_rd_data;
    logic              forwarder_done;
    logic              ready_for_forwarder;
    logic [PL-1:0]     len_to_forwarder;
    logic [N-1:0]      buf_ready;
    logic [N*PL-1:0]   buf_len;
    logic [AW-1:0]     buf_rd_addr;
    logic [N-1:0]      buf_rd_en;
    logic [N*DW-1:0]   buf_rd_data;
    logic [N-1:0]      buf_done;

    logic [PL-1:0] lens [N] = '{10'd20, 10'd30, 10'd16, 10'd40};
    localparam logic [DW-1:0] D0 = 64'h1111_1111_1111_1111;
    localparam logic [DW-1:0] D1 = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [DW-1:0] D2 = 64'h2222_2222_2222_2222;
    localparam logic [DW-1:0] D3 = 64'h3333_3333_3333_3333;

    assign buf_len     = {lens[3], lens[2], lens[1], lens[0]};
    assign buf_rd_data = {D3, D2, D1, D0};

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    fwd_buf_arbiter #(.N_BUFS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .forwarder_rd_addr   (forwarder_rd_addr),
        .forwarder_rd_en     (forwarder_rd_en),
        .forwarder_rd_data   (forwarder_rd_data),
        .forwarder_done      (forwarder_done),
        .ready_for_forwarder (ready_for_forwarder),
        .len_to_forwarder    (len_to_forwarder),
        .buf_ready           (buf_ready),
        .buf_len             (buf_len),
        .buf_rd_addr         (buf_rd_addr),
        .buf_rd_en           (buf_rd_en),
        .buf_rd_data         (buf_rd_data),
        .buf_done            (buf_done)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Waits for a grant, pops the expected buffer, runs beats cycles, releases.
    task automatic serve_packet(input int beats, input int exp_waits);
        int waits;
        int g;
        logic [N-1:0]  oh;
        logic [AW-1:0] addr;
        waits = 0;
        while (ready_for_forwarder !== 1'b1 && waits < 20) begin
            @(negedge clk);
            #1;
            waits++;
        end
        total++;
        if (ready_for_forwarder !== 1'b1) begin
            bad++;
            $display("FAIL grant_timeout: ready=%b required=1", ready_for_forwarder);
            return;
        end
        if (exp_waits >= 0) begin
            total++;
            if (waits != exp_waits) begin
                bad++;
                $display("FAIL idle_gap: cycles=%0d required=%0d", waits, exp_waits);
            end
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: grant seen with nothing expected");
            return;
        end
        g = exp_q.pop_front();
        oh = '0;
        oh[g] = 1'b1;
        addr = AW'(g * 7 + 1);
        forwarder_rd_en   = 1'b1;
        forwarder_rd_addr = addr;
        #1;
        total++;
        if (buf_rd_en !== oh) begin
            bad++;
            $display("FAIL grant_rd_en: buf_rd_en=%b required=%b", buf_rd_en, oh);
        end
        total++;
        if (buf_rd_addr !== addr) begin
            bad++;
            $display("FAIL rd_addr: buf_rd_addr=%h required=%h", buf_rd_addr, addr);
        end
        total++;
        if (len_to_forwarder !== lens[g]) begin
            bad++;
            $display("FAIL grant_len: len=%0d required=%0d", len_to_forwarder, lens[g]);
        end
        repeat (beats - 1) begin
            @(negedge clk);
            #1;
        end
        forwarder_rd_en = 1'b0;
        forwarder_done  = 1'b1;
        #1;
        total++;
        if (buf_done !== oh) begin
            bad++;
            $display("FAIL release_pulse: buf_done=%b required=%b", buf_done, oh);
        end
        @(negedge clk);
        forwarder_done = 1'b0;
        #1;
        total++;
        if (buf_done !== '0 || ready_for_forwarder !== 1'b0) begin
            bad++;
            $display("FAIL release_idle: buf_done=%b ready=%b required 0000/0",
                     buf_done, ready_for_forwarder);
        end
    endtask

    task automatic test_reset();
        forwarder_rd_addr = '0;
        forwarder_rd_en   = 1'b0;
        forwarder_done    = 1'b0;
        buf_ready         = '0;
        do_reset();
        total++;
        if (ready_for_forwarder !== 1'b0 || len_to_forwarder !== '0 ||
            buf_rd_en !== '0 || buf_done !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b len=%0d rd_en=%b done=%b required all 0",
                     ready_for_forwarder, len_to_forwarder, buf_rd_en, buf_done);
        end
        total++;
        if (forwarder_rd_data !== D0) begin
            bad++;
            $display("FAIL reset_sel: rd_data=%h required=%h", forwarder_rd_data, D0);
        end
        forwarder_rd_en = 1'b1;
        forwarder_done  = 1'b1;
        #1;
        total++;
        if (buf_rd_en !== '0 || buf_done !== '0) begin
            bad++;
            $display("FAIL idle_gating: rd_en=%b done=%b required 0000", buf_rd_en, buf_done);
        end
        @(negedge clk);
        forwarder_rd_en = 1'b0;
        forwarder_done  = 1'b0;
        #1;
    endtask

    task automatic test_single();
        buf_ready = 4'b0100;
        #1;
        total++;
        if (ready_for_forwarder !== 1'b0) begin
            bad++;
            $display("FAIL single_latency: ready=%b required=0 before edge", ready_for_forwarder);
        end
        exp_q.push_back(2);
        serve_packet(3, 1);
        buf_ready = '0;
    endtask

    task automatic test_round_robin();
        do_reset();
        buf_ready = 4'b1111;
        for (int k = 0; k < 8; k++) exp_q.push_back(k % 4);
        for (int k = 0; k < 8; k++) serve_packet(2, 1);
        // Wrap/skip: pointer now sits at 3, only buffer 2 requests.
        buf_ready = 4'b0100;
        exp_q.push_back(2);
        serve_packet(2, 1);
        buf_ready = '0;
    endtask

    task automatic test_data_mux();
        do_reset();
        total++;
        if (forwarder_rd_data !== D0) begin
            bad++;
            $display("FAIL mux_initial: rd_data=%h required=%h", forwarder_rd_data, D0);
        end
        buf_ready = 4'b0010;
        exp_q.push_back(1);
        serve_packet(4, 1);
        total++;
        if (forwarder_rd_data !== D1) begin
            bad++;
            $display("FAIL mux_after_done: rd_data=%h required=%h", forwarder_rd_data, D1);
        end
        buf_ready = '0;
        @(negedge clk);
        #1;
        total++;
        if (forwarder_rd_data !== D1) begin
            bad++;
            $display("FAIL mux_hold_idle: rd_data=%h required=%h", forwarder_rd_data, D1);
        end
    endtask

    task automatic test_reset_mid();
        buf_ready = 4'b0100;
        @(negedge clk);
        #1;
        forwarder_rd_en = 1'b1;
        #1;
        total++;
        if (ready_for_forwarder !== 1'b1 || buf_rd_en !== 4'b0100) begin
            bad++;
            $display("FAIL mid_busy: ready=%b rd_en=%b required 1/0100",
                     ready_for_forwarder, buf_rd_en);
        end
        rst = 1'b1;
        forwarder_rd_en = 1'b0;
        #1;
        total++;
        if (buf_done !== '0) begin
            bad++;
            $display("FAIL mid_reset_done: buf_done=%b required=0000", buf_done);
        end
        @(negedge clk);
        rst = 1'b0;
        buf_ready = 4'b0110;
        #1;
        total++;
        if (ready_for_forwarder !== 1'b0 || len_to_forwarder !== '0 ||
            buf_rd_en !== '0 || buf_done !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: ready=%b len=%0d rd_en=%b done=%b required all 0",
                     ready_for_forwarder, len_to_forwarder, buf_rd_en, buf_done);
        end
        exp_q.push_back(1);
        exp_q.push_back(2);
        serve_packet(2, 1);
        serve_packet(2, 1);
        buf_ready = '0;
    endtask

    task automatic test_spurious_stall();
        @(negedge clk);
        forwarder_done = 1'b1;
        #1;
        total++;
        if (buf_done !== '0) begin
            bad++;
            $display("FAIL spurious_done: buf_done=%b required=0000", buf_done);
        end
        @(negedge clk);
        forwarder_done = 1'b0;
        buf_ready = 4'b1000;
        #1;
        total++;
        if (ready_for_forwarder !== 1'b0) begin
            bad++;
            $display("FAIL spurious_state: ready=%b required=0", ready_for_forwarder);
        end
        @(negedge clk);
        forwarder_rd_en = 1'b1;
        #1;
        total++;
        if (ready_for_forwarder !== 1'b1 || buf_rd_en !== 4'b1000) begin
            bad++;
            $display("FAIL stall_grant: ready=%b rd_en=%b required 1/1000",
                     ready_for_forwarder, buf_rd_en);
        end
        buf_ready = '0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (ready_for_forwarder !== 1'b0 || buf_rd_en !== 4'b1000) begin
                bad++;
                $display("FAIL stall_cycle%0d: ready=%b rd_en=%b required 0/1000",
                         k, ready_for_forwarder, buf_rd_en);
            end
            if (k < 2) begin
                @(negedge clk);
                #1;
            end
        end
        @(negedge clk);
        buf_ready = 4'b1000;
        #1;
        total++;
        if (ready_for_forwarder !== 1'b1) begin
            bad++;
            $display("FAIL stall_resume: ready=%b required=1", ready_for_forwarder);
        end
        forwarder_rd_en = 1'b0;
        forwarder_done  = 1'b1;
        #1;
        total++;
        if (buf_done !== 4'b1000) begin
            bad++;
            $display("FAIL stall_release: buf_done=%b required=1000", buf_done);
        end
        @(negedge clk);
        forwarder_done = 1'b0;
        buf_ready = '0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_data_mux();
        test_reset_mid();
        test_spurious_stall();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: entries=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
